// File: rtl/bram_axi_pkg.sv
// Shared AXI4 write constants and arbiter FSM state encoding for the sample BRAM path.
package bram_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [2:0] SIZE_4B     = 3'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select; the search starts at ptr_i and wraps.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_onehot_o,
  output logic [IdxW-1:0]   grant_idx_o,
  output logic              any_grant_o
);

  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] sel;
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    any_grant_o    = 1'b0;
    idx            = 0;
    sel            = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      // ptr_i is always below NumReq, so a single wrap subtraction suffices
      idx = 32'(ptr_i) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      sel = IdxW'(idx);
      if (!any_grant_o && req_i[sel]) begin
        any_grant_o         = 1'b1;
        grant_idx_o         = sel;
        grant_onehot_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 single-beat write master among NUM_REQ requesters.
module bram_write_arbiter
  import bram_axi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      ack_err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_W-1:0]         wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     win_q, win_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                ack_err_q, ack_err_d;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [IdxW-1:0]     grant_idx;
  logic                any_grant;

  // Masking with the live ack stops a requester re-winning in its own ack cycle
  assign eligible = req & ~ack_q;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_arbiter (
    .req_i          (eligible),
    .ptr_i          (ptr_q),
    .grant_onehot_o (grant_onehot),
    .grant_idx_o    (grant_idx),
    .any_grant_o    (any_grant)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    ack_d     = '0;
    ack_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_grant) begin
          win_d     = grant_idx;
          awaddr_d  = ADDR_W'(req_addr >> (32'(grant_idx) * ADDR_W));
          wdata_d   = DATA_W'(req_data >> (32'(grant_idx) * DATA_W));
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        aw_pend_d = aw_pend_q & ~awready;
        w_pend_d  = w_pend_q & ~wready;
        if (!aw_pend_d && !w_pend_d) state_d = StResp;
      end
      StResp: begin
        if (bvalid) begin
          ack_d[win_q] = 1'b1;
          ack_err_d    = (bresp != RESP_OKAY);
          ptr_d        = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + IdxW'(1);
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ack_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ack_q     <= ack_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign ack     = ack_q;
  assign ack_err = ack_err_q;
  assign busy    = (state_q != StIdle);
  assign awaddr  = awaddr_q;
  assign awlen   = 8'd0;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_FIXED;
  assign awvalid = (state_q == StXfer) && aw_pend_q;
  assign wdata   = wdata_q;
  assign wstrb   = 4'hF;
  assign wvalid  = (state_q == StXfer) && w_pend_q;
  assign wlast   = wvalid;
  assign bready  = (state_q == StResp);

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed bench for bram_write_arbiter: transaction-level reference model plus literal checks.
module tb_bram_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 32;

  logic            aclk, rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic            ack_err, busy;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [3:0]      wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;

  int tests = 0;
  int fails = 0;

  bram_write_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .aclk     (aclk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .ack_err  (ack_err),
    .busy     (busy),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding write, tracked as "which channels are still owed"
  logic          m_txn, m_aw_done, m_w_done, m_resp, m_err;
  logic [N-1:0]  m_ack, m_elig;
  int            m_ptr, m_idx, m_win, m_j;
  logic          m_found;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  always_comb begin
    m_elig  = req & ~m_ack;
    m_win   = 0;
    m_found = 1'b0;
    m_j     = 0;
    for (int k = 0; k < N; k++) begin
      m_j = (m_ptr + k) % N;
      if (!m_found && m_elig[m_j]) begin
        m_found = 1'b1;
        m_win   = m_j;
      end
    end
  end

  always @(posedge aclk or negedge rst) begin
    if (!rst) begin
      m_txn <= 1'b0; m_aw_done <= 1'b0; m_w_done <= 1'b0; m_resp <= 1'b0;
      m_ack <= '0; m_err <= 1'b0; m_ptr <= 0; m_idx <= 0; m_addr <= '0; m_data <= '0;
    end else begin
      m_ack <= '0;
      m_err <= 1'b0;
      if (!m_txn) begin
        if (m_found) begin
          m_txn     <= 1'b1;
          m_idx     <= m_win;
          m_addr    <= AW'(req_addr >> (m_win * AW));
          m_data    <= DW'(req_data >> (m_win * DW));
          m_aw_done <= 1'b0;
          m_w_done  <= 1'b0;
        end
      end else if (!m_resp) begin
        m_aw_done <= m_aw_done | awready;
        m_w_done  <= m_w_done | wready;
        if ((m_aw_done | awready) && (m_w_done | wready)) m_resp <= 1'b1;
      end else if (bvalid) begin
        m_ack  <= N'(1) << m_idx;
        m_err  <= (bresp != 2'b00);
        m_ptr  <= (m_idx + 1) % N;
        m_txn  <= 1'b0;
        m_resp <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, plus handshake bookkeeping
  int            aw_hs = 0, w_hs = 0;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_data;
  logic [3:0]    hs_strb;
  logic          hs_last;

  always @(negedge aclk) begin
    chk("ack", 64'(ack), 64'(m_ack));
    chk("ack_err", 64'(ack_err), 64'(m_err));
    chk("busy", 64'(busy), 64'(m_txn));
    chk("awvalid", 64'(awvalid), 64'(m_txn && !m_resp && !m_aw_done));
    chk("wvalid", 64'(wvalid), 64'(m_txn && !m_resp && !m_w_done));
    chk("wlast", 64'(wlast), 64'(m_txn && !m_resp && !m_w_done));
    chk("bready", 64'(bready), 64'(m_resp));
    chk("awaddr", 64'(awaddr), 64'(m_addr));
    chk("wdata", 64'(wdata), 64'(m_data));
    chk("consts", 64'({awlen, awsize, awburst, wstrb}), 64'({8'd0, 3'd2, 2'b00, 4'hF}));
    if (rst && awvalid && awready) begin
      aw_hs++;
      hs_addr = awaddr;
    end
    if (rst && wvalid && wready) begin
      w_hs++;
      hs_data = wdata;
      hs_strb = wstrb;
      hs_last = wlast;
    end
  end

  // AXI slave B channel: bvalid one cycle after bready is seen, dropped after the handshake
  logic b_auto, stray_bv, s_bready, s_fire;
  initial begin
    bvalid = 1'b0;
    forever begin
      @(negedge aclk);
      s_bready = bready;
      s_fire   = bvalid && bready;
      @(posedge aclk);
      #1;
      if (!rst) bvalid = 1'b0;
      else if (b_auto) begin
        if (s_fire) bvalid = 1'b0;
        else if (s_bready) bvalid = 1'b1;
      end else bvalid = stray_bv;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic wait_ack(output logic [N-1:0] a, output logic e);
    a = '0;
    e = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (ack != '0) begin
        a = ack;
        e = ack_err;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL ack_timeout: got no ack, expected one within 60 cycles (t=%0t)", $time);
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [N-1:0] a;
  logic         e;
  int           order[6];
  int           exp_order[6];
  int           aw0, w0;

  initial begin
    exp_order = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0;
    awready = 1'b1; wready = 1'b1; bresp = 2'b00; b_auto = 1'b1; stray_bv = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_valids", 64'({awvalid, wvalid, wlast, bready}), 64'h0);
    chk("rst_ack", 64'({ack, ack_err}), 64'h0);
    chk("rst_data", 64'({awaddr, wdata}), 64'h0);
    repeat (2) @(posedge aclk);
    #1 rst = 1'b1;
    tick();

    // All four requesting continuously
    for (int i = 0; i < N; i++) set_req(i, AW'(16'h100 + i * 4), DW'(32'hA0 + i));
    req = 4'hF;
    for (int n = 0; n < 6; n++) begin
      wait_ack(a, e);
      order[n] = onehot_idx(a);
      chk("rr_onehot", 64'($countones(a)), 64'h1);
      if (n == 5) req = '0;
    end
    for (int n = 0; n < 6; n++) chk("rr_order", 64'(order[n]), 64'(exp_order[n]));
    repeat (2) tick();

    // Single requester, latency and beat contents
    aw0 = aw_hs; w0 = w_hs;
    set_req(2, 15'h0010, 32'hDEADBEEF);
    req = 4'b0100;
    repeat (3) tick();
    chk("single_no_early_ack", 64'(ack), 64'h0);
    tick();
    chk("single_ack_c4", 64'(ack), 64'h4);
    chk("single_ack_err", 64'(ack_err), 64'h0);
    tick();
    req = '0;
    chk("single_aw_hs", 64'(aw_hs - aw0), 64'h1);
    chk("single_w_hs", 64'(w_hs - w0), 64'h1);
    chk("single_awaddr", 64'(hs_addr), 64'h10);
    chk("single_wdata", 64'(hs_data), 64'hDEADBEEF);
    chk("single_wlast_wstrb", 64'({hs_last, hs_strb}), 64'h1F);

    // Error response on requester 1, then a normal write
    bresp = 2'b10;
    set_req(1, 15'h0020, 32'h11111111);
    req = 4'b0010;
    wait_ack(a, e);
    chk("err_ack", 64'(a), 64'h2);
    chk("err_flag", 64'(e), 64'h1);
    tick();
    req = '0; bresp = 2'b00;
    set_req(3, 15'h0030, 32'h33333333);
    req = 4'b1000;
    wait_ack(a, e);
    chk("post_err_ack", 64'(a), 64'h8);
    chk("post_err_flag", 64'(e), 64'h0);
    tick();
    req = '0;

    // awready held low for 3 cycles
    aw0 = aw_hs; w0 = w_hs;
    awready = 1'b0;
    set_req(0, 15'h0044, 32'h44444444);
    req = 4'b0001;
    repeat (3) tick();
    chk("skew_aw_held", 64'({awvalid, wvalid, bready}), 64'h4);
    awready = 1'b1;
    wait_ack(a, e);
    chk("skew_aw_ack", 64'(a), 64'h1);
    tick();
    req = '0;
    // wready held low for 3 cycles
    wready = 1'b0;
    set_req(1, 15'h0048, 32'h48484848);
    req = 4'b0010;
    repeat (3) tick();
    chk("skew_w_held", 64'({awvalid, wvalid, bready}), 64'h2);
    wready = 1'b1;
    wait_ack(a, e);
    chk("skew_w_ack", 64'(a), 64'h2);
    tick();
    req = '0;
    chk("skew_aw_hs", 64'(aw_hs - aw0), 64'h2);
    chk("skew_w_hs", 64'(w_hs - w0), 64'h2);

    // Requester drops req right after the grant
    set_req(2, 15'h0050, 32'h55555555);
    req = 4'b0100;
    tick();
    req = '0;
    wait_ack(a, e);
    chk("drop_ack", 64'(a), 64'h4);
    repeat (5) tick();
    chk("drop_no_regrant", 64'(busy), 64'h0);

    // bvalid while idle must be ignored
    b_auto = 1'b0; stray_bv = 1'b1;
    repeat (3) tick();
    chk("stray_b_ack", 64'({ack, busy}), 64'h0);
    stray_bv = 1'b0;
    tick();
    b_auto = 1'b1;

    // Reset while awvalid is up
    awready = 1'b0;
    set_req(3, 15'h0060, 32'h66666666);
    req = 4'b1000;
    repeat (2) tick();
    chk("pre_reset_aw", 64'(awvalid), 64'h1);
    rst = 1'b0;
    #1;
    chk("reset_async_valids", 64'({awvalid, wvalid, bready, busy}), 64'h0);
    repeat (2) @(posedge aclk);
    #1 rst = 1'b1;
    awready = 1'b1;
    set_req(0, 15'h0070, 32'h77777777);
    req = 4'b1001;
    wait_ack(a, e);
    chk("reset_ptr_winner", 64'(a), 64'h1);
    tick();
    req = 4'b1000;
    wait_ack(a, e);
    chk("reset_next_winner", 64'(a), 64'h8);
    tick();
    req = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
